// File: rtl/seq_detect_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_detect_ctrl
// Front-end controller for the serial sequence detector path. Parallel words
// arrive over a valid/ready handshake. Each word is serialised MSB-first, one
// bit per clock. The bit stream is matched against a programmable, maskable
// pattern, and overlapping matches count. Matches are counted with saturation,
// and a sticky interrupt is raised when the count reaches a programmed
// threshold.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   en           enable acceptance of new words
//   cfg_we       config write strobe, honoured only while idle
//   cfg_pattern  pattern to match; bit PAT_W-1 is the oldest bit
//   cfg_mask     1 = compare this bit, 0 = don't care
//   cfg_thresh   irq threshold; 0 disables irq
//   in_valid     input word valid
//   in_data      input word
//   in_ready     controller can take a word this cycle
//   seq_out      serial bit currently being evaluated
//   seq_vld      seq_out is valid this cycle
//   match        one-cycle pulse: pattern matched
//   match_cnt    saturating match count
//   irq          sticky threshold interrupt
//   irq_clr      clears irq
//   busy         high while shifting a word out
// -----------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [PAT_W-1:0]  cfg_mask,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              seq_out,
  output logic              seq_vld,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  // fill+1 >= PAT_W rewritten so no extra carry bit is needed
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WORD_W-1:0]  r_shreg;
  logic [BIT_W-1:0]   r_bitcnt;
  logic [PAT_W-1:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_W-1:0]   r_pattern;
  logic [PAT_W-1:0]   r_mask;
  logic [CNT_W-1:0]   r_thresh;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_irq;

  logic               w_load;
  logic               w_bit;
  logic [PAT_W-1:0]   w_hist_next;
  logic               w_hit;
  logic               w_cfg;
  logic               w_cnt_inc;
  logic [CNT_W-1:0]   w_cnt_plus;
  logic               w_irq_set;

  assign w_bit       = r_shreg[WORD_W-1];
  assign w_hist_next = {r_hist[PAT_W-2:0], w_bit};
  assign w_hit       = (r_fill >= FILL_THR) &&
                       (((w_hist_next ^ r_pattern) & r_mask) == '0);
  assign w_cfg       = cfg_we && (r_state == ST_IDLE);
  assign w_cnt_plus  = r_cnt + CNT_W'(1);
  assign w_cnt_inc   = r_match && (r_cnt != CNT_MAX);
  // Only a real transition onto the threshold raises irq; a saturated
  // counter that happens to sit at the threshold does not re-fire.
  assign w_irq_set   = w_cnt_inc && (r_thresh != '0) && (w_cnt_plus == r_thresh);

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign irq       = r_irq;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    in_ready     = 1'b0;
    seq_out      = 1'b0;
    seq_vld      = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Held low during reset so no handshake completes into a reset edge.
        in_ready = en & ~rst;
        if (in_valid && en) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        seq_out = w_bit;
        seq_vld = 1'b1;
        busy    = 1'b1;
        // Last bit of the word: a new word may be taken without a bubble.
        if (r_bitcnt == '0) begin
          in_ready = en & ~rst;
          if (in_valid && en) w_load = 1'b1;
          else                w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_RST;
      r_mask    <= '1;
      r_thresh  <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_load) begin
        r_shreg  <= in_data;
        r_bitcnt <= BIT_LAST;
      end else if (r_state == ST_SHIFT) begin
        r_shreg  <= {r_shreg[WORD_W-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - BIT_W'(1);
      end

      if (w_cfg) begin
        r_pattern <= cfg_pattern;
        r_mask    <= cfg_mask;
        r_thresh  <= cfg_thresh;
        r_hist    <= '0;
        r_fill    <= '0;
        r_match   <= 1'b0;
        r_cnt     <= '0;
        r_irq     <= 1'b0;
      end else begin
        if (r_state == ST_SHIFT) begin
          r_hist  <= w_hist_next;
          r_match <= w_hit;
          if (r_fill != FILL_MAX) r_fill <= r_fill + FILL_W'(1);
        end else begin
          r_match <= 1'b0;
        end
        // Counter and irq follow the visible match pulse by one cycle, so an
        // irq_clr issued during that pulse loses to the set.
        if (w_cnt_inc) r_cnt <= w_cnt_plus;
        if (w_irq_set)    r_irq <= 1'b1;
        else if (irq_clr) r_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
`timescale 1ns/1ps
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cfg_we, in_valid, irq_clr;
  logic [3:0] cfg_pattern, cfg_mask;
  logic [7:0] cfg_thresh, in_data;
  logic       in_ready, seq_out, seq_vld, match, irq, busy;
  logic [7:0] match_cnt;
  logic       in_ready2, seq_out2, seq_vld2, match2, irq2, busy2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .seq_out(seq_out), .seq_vld(seq_vld), .match(match), .match_cnt(match_cnt),
    .irq(irq), .irq_clr(irq_clr), .busy(busy)
  );

  // Narrow-counter instance to exercise saturation; shares all inputs.
  seq_detect_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_thresh(cfg_thresh[1:0]),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .seq_out(seq_out2), .seq_vld(seq_vld2), .match(match2), .match_cnt(match_cnt2),
    .irq(irq2), .irq_clr(irq_clr), .busy(busy2)
  );

  typedef struct packed {
    logic       en, vld;
    logic [7:0] d;
    logic       cfg;
    logic       rdy, so, sv, m;
    logic [7:0] cnt;
    logic       irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic v, input logic [7:0] d, input logic c,
                     input logic rdy, input logic so, input logic sv, input logic m,
                     input logic [7:0] cnt, input logic iq);
    vec_t r;
    r.en = e; r.vld = v; r.d = d; r.cfg = c;
    r.rdy = rdy; r.so = so; r.sv = sv; r.m = m; r.cnt = cnt; r.irq = iq;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [3:0] p, input logic [3:0] m, input logic [7:0] t);
    cfg_pattern = p; cfg_mask = m; cfg_thresh = t;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    $display("cfg pattern=%b mask=%b thresh=%0d", p, m, t);
  endtask

  // Sends one word from IDLE, then records match/irq over the 8 bit cycles and
  // the following idle cycle (MSB of the vectors = first bit cycle).
  task automatic send_word(input logic [7:0] d, input int cfg_at, input int clr_at,
                           output logic [8:0] mp, output logic [8:0] mi);
    int guard;
    en = 1'b1; in_valid = 1'b1; in_data = d;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cfg_we  = (i == cfg_at);
      irq_clr = (i == clr_at);
      #1;
      mp[8-i] = match;
      mi[8-i] = irq;
      step();
    end
    cfg_we = 1'b0; irq_clr = 1'b0;
    $display("word %02h: pulses=%b irq=%b cnt=%0d cnt2=%0d", d, mp, mi, match_cnt, match_cnt2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] mp, mi;
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'hB6; cfg_we = 1'b0;
    cfg_pattern = 4'b1011; cfg_mask = 4'hF; cfg_thresh = 8'd0; irq_clr = 1'b0;

    //   en v  data  cfg rdy so sv m  cnt irq
    // Word B6 from reset: matches after bits 4 and 7.
    add(1, 1, 8'hB6, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 2, 0);
    // Config write in IDLE clears count and history.
    add(0, 0, 8'h00, 1, 0, 0, 0, 0, 2, 0);
    // Two words back-to-back: 16 contiguous bits, 4 matches.
    add(1, 1, 8'hB6, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0);
    add(1, 1, 8'hB6, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 2, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0, 2, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 2, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 2, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 1, 2, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 3, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0, 3, 0);
    add(1, 0, 8'h00, 0, 1, 0, 1, 1, 3, 0);
    add(1, 0, 8'h00, 0, 1, 0, 0, 0, 4, 0);
    // en dropped mid-word: word completes, pending word not taken.
    add(1, 1, 8'hB6, 0, 1, 0, 0, 0, 4, 0);
    add(0, 1, 8'hB6, 0, 0, 1, 1, 0, 4, 0);
    add(0, 1, 8'hB6, 0, 0, 0, 1, 0, 4, 0);
    add(0, 1, 8'hB6, 0, 0, 1, 1, 0, 4, 0);
    add(0, 1, 8'hB6, 0, 0, 1, 1, 0, 4, 0);
    add(0, 1, 8'hB6, 0, 0, 0, 1, 1, 4, 0);
    add(0, 1, 8'hB6, 0, 0, 1, 1, 0, 5, 0);
    add(0, 1, 8'hB6, 0, 0, 1, 1, 0, 5, 0);
    add(0, 1, 8'hB6, 0, 0, 0, 1, 1, 5, 0);
    add(0, 1, 8'hB6, 0, 0, 0, 0, 0, 6, 0);
    add(0, 1, 8'hB6, 0, 0, 0, 0, 0, 6, 0);

    // Reset state (rst still asserted, en and in_valid high).
    step(); step();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.seq_vld", seq_vld, 0);
    chk("rst.seq_out", seq_out, 0);
    chk("rst.busy", busy, 0);
    chk("rst.match", match, 0);
    chk("rst.match_cnt", match_cnt, 0);
    chk("rst.irq", irq, 0);
    $display("reset: in_ready=%b busy=%b cnt=%0d", in_ready, busy, match_cnt);
    rst = 1'b0; in_valid = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; in_valid = tbl[i].vld; in_data = tbl[i].d; cfg_we = tbl[i].cfg;
      #1;
      chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].rdy);
      chk($sformatf("vec%0d.seq_out", i), seq_out, tbl[i].so);
      chk($sformatf("vec%0d.seq_vld", i), seq_vld, tbl[i].sv);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].sv);
      chk($sformatf("vec%0d.match", i), match, tbl[i].m);
      chk($sformatf("vec%0d.match_cnt", i), match_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d.irq", i), irq, tbl[i].irq);
      $display("vec %0d: rdy=%b out=%b vld=%b match=%b cnt=%0d", i, in_ready, seq_out,
               seq_vld, match, match_cnt);
      step();
    end
    cfg_we = 1'b0; in_valid = 1'b0; en = 1'b1;
    step();

    // Threshold 3: irq rises with the 3rd count; clear during that pulse loses.
    do_cfg(4'b1011, 4'hF, 8'd3);
    send_word(8'hB6, -1, -1, mp, mi);
    chk("thr.w1.pulses", mp, 9'b000010010);
    chk("thr.w1.irq", mi, 9'b000000000);
    chk("thr.w1.cnt", match_cnt, 2);
    send_word(8'hB6, -1, 4, mp, mi);
    chk("thr.w2.pulses", mp, 9'b000010010);
    chk("thr.w2.irq", mi, 9'b000001111);
    chk("thr.w2.cnt", match_cnt, 4);
    chk("thr.w2.cnt2_sat", match_cnt2, 3);
    chk("thr.w2.irq2", irq2, 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("clr.irq", irq, 0);
    chk("clr.irq2", irq2, 0);
    chk("clr.cnt", match_cnt, 4);

    // Threshold 1, then a config write in IDLE clears count and irq.
    do_cfg(4'b1011, 4'hF, 8'd1);
    send_word(8'hB6, -1, -1, mp, mi);
    chk("thr1.irq", mi, 9'b000001111);
    chk("thr1.irq2", irq2, 1);
    chk("thr1.cnt2", match_cnt2, 2);
    do_cfg(4'b1001, 4'b1001, 8'd0);
    chk("cfgclr.cnt", match_cnt, 0);
    chk("cfgclr.irq", irq, 0);
    chk("cfgclr.cnt2", match_cnt2, 0);
    chk("cfgclr.irq2", irq2, 0);

    // Masked pattern on FF; a config write mid-word must be ignored.
    cfg_pattern = 4'b0000; cfg_mask = 4'b1111; cfg_thresh = 8'd0;
    send_word(8'hFF, 1, -1, mp, mi);
    chk("mask.pulses", mp, 9'b000011111);
    chk("mask.cnt", match_cnt, 5);
    chk("mask.cnt2_sat", match_cnt2, 3);

    // All-don't-care pattern: matches only once PAT_W bits have been seen.
    do_cfg(4'b0000, 4'b0000, 8'd0);
    send_word(8'h00, -1, -1, mp, mi);
    chk("fill.pulses", mp, 9'b000011111);
    chk("fill.cnt", match_cnt, 5);

    // Reset during bit 3 drops the word; next word sees fresh history.
    en = 1'b1; in_valid = 1'b1; in_data = 8'hB0;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rstmid.busy", busy, 0);
    chk("rstmid.seq_vld", seq_vld, 0);
    chk("rstmid.in_ready", in_ready, 0);
    chk("rstmid.match_cnt", match_cnt, 0);
    $display("reset mid-word: busy=%b vld=%b rdy=%b", busy, seq_vld, in_ready);
    rst = 1'b0;
    step();
    send_word(8'hD9, -1, -1, mp, mi);
    chk("fresh.pulses", mp, 9'b000001000);
    chk("fresh.cnt", match_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
